tx: RTL

// UART transmitter: serializes one byte per Send/Sent handshake onto Sout.

---
 rtl/tx.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/tx.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, odd parity, then stop bit(s).
// Build option TX_TWO_STOP_EN selects two stop bits; the default build sends one stop bit.
module tx #(
    parameter int BAUD_CYCLES = 5208
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Send,
    input  logic [7:0] Din,
    output logic       Sent,
    output logic       Sout,
    output logic       Busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BITS  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4,
        ACK   = 3'd5
    } state_t;

    localparam logic [12:0] BAUD_LAST = 13'(BAUD_CYCLES - 1);

    state_t      state_reg;
    state_t      state_next;
    logic [12:0] timer_reg;
    logic [12:0] timer_next;
    logic        timer_done;
    logic [2:0]  bit_cnt_reg;
    logic [2:0]  bit_cnt_next;
    logic [7:0]  shift_reg;
    logic [7:0]  shift_next;
    logic        parity_reg;
    logic        parity_next;
    logic        sout_reg;
    logic        sout_next;
`ifdef TX_TWO_STOP_EN
    logic        stop_half_reg;
    logic        stop_half_next;
`endif

    assign timer_done = (timer_reg == BAUD_LAST);

    // State register and datapath flops; Sout is a flop so the line never glitches.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_reg     <= IDLE;
            timer_reg     <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            parity_reg    <= 1'b0;
            sout_reg      <= 1'b1;
`ifdef TX_TWO_STOP_EN
            stop_half_reg <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            parity_reg    <= parity_next;
            sout_reg      <= sout_next;
`ifdef TX_TWO_STOP_EN
            stop_half_reg <= stop_half_next;
`endif
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        parity_next  = parity_reg;
`ifdef TX_TWO_STOP_EN
        stop_half_next = stop_half_reg;
`endif
        case (state_reg)
            IDLE: begin
                bit_cnt_next = '0;
                if (Send) begin
                    shift_next  = Din;
                    parity_next = ~^Din;
                    state_next  = START;
                end
            end
            START: begin
                if (timer_done) begin
                    bit_cnt_next = '0;
                    state_next   = BITS;
                end
            end
            BITS: begin
                if (timer_done) begin
                    shift_next   = {1'b0, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = PAR;
                    end
                end
            end
            PAR: begin
                if (timer_done) begin
                    state_next = STOP;
`ifdef TX_TWO_STOP_EN
                    stop_half_next = 1'b0;
`endif
                end
            end
            STOP: begin
                if (timer_done) begin
`ifdef TX_TWO_STOP_EN
                    if (stop_half_reg) begin
                        state_next = ACK;
                    end else begin
                        stop_half_next = 1'b1;
                    end
`else
                    state_next = ACK;
`endif
                end
            end
            ACK: begin
                if (!Send) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Timer restarts at every bit boundary so each bit is exactly BAUD_CYCLES clocks.
        if (state_reg == IDLE || state_reg == ACK || state_next != state_reg || timer_done) begin
            timer_next = '0;
        end else begin
            timer_next = timer_reg + 13'd1;
        end
    end

    // Outputs: Sout is precomputed from the next state so it changes on the same edge.
    always_comb begin
        sout_next = 1'b1;
        case (state_next)
            IDLE:    sout_next = 1'b1;
            START:   sout_next = 1'b0;
            BITS:    sout_next = shift_next[0];
            PAR:     sout_next = parity_next;
            STOP:    sout_next = 1'b1;
            ACK:     sout_next = 1'b1;
            default: sout_next = 1'b1;
        endcase
        Sent = (state_reg == ACK);
        Busy = (state_reg != IDLE);
        Sout = sout_reg;
    end

endmodule
